// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  // Sample points relative to Prescale/2; the vote lands one edge after the last sample
  localparam int SMP_OFS_FIRST = -1;
  localparam int SMP_OFS_MID   = 0;
  localparam int SMP_OFS_LAST  = 1;
  localparam int SMP_OFS_VOTE  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point oversampler around mid-bit with a registered majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_i,
  input  logic [PRESC_W-1:0] edge_cnt_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               sampled_bit_o
);

  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] tgt_first, tgt_mid, tgt_last, tgt_vote;
  logic [2:0]         smp_q, smp_d;
  logic               bit_q, bit_d;

  assign half      = prescale_i >> 1;
  assign tgt_first = half + PRESC_W'(SMP_OFS_FIRST);
  assign tgt_mid   = half + PRESC_W'(SMP_OFS_MID);
  assign tgt_last  = half + PRESC_W'(SMP_OFS_LAST);
  assign tgt_vote  = half + PRESC_W'(SMP_OFS_VOTE);

  always_comb begin
    smp_d = smp_q;
    bit_d = bit_q;
    if (edge_cnt_i == tgt_first) smp_d[0] = rx_i;
    if (edge_cnt_i == tgt_mid)   smp_d[1] = rx_i;
    if (edge_cnt_i == tgt_last)  smp_d[2] = rx_i;
    if (edge_cnt_i == tgt_vote)
      bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_q <= '1;
      bit_q <= 1'b1;
    end else begin
      smp_q <= smp_d;
      bit_q <= bit_d;
    end
  end

  assign sampled_bit_o = bit_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame sequencer: start detect, LSB-first deserialiser, parity/stop checks.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_err,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic                  data_valid,
  output logic                  par_err_flag,
  output logic                  stp_err,
  output logic                  strt_glitch
);
  import uart_rx_pkg::*;

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [PRESC_W-1:0]    edge_q, edge_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  stp_q, stp_d;
  logic                  dv_q, dv_d;
  logic                  glitch_q, glitch_d;
  logic                  eob;
  logic [PRESC_W-1:0]    vote_edge;
  logic                  unused_par_typ;

  // Parity type is consumed by the external checker only
  assign unused_par_typ = PAR_TYP;

  assign eob       = (edge_q == presc_q - PRESC_W'(1));
  assign vote_edge = (presc_q >> 1) + PRESC_W'(SMP_OFS_VOTE);

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk_i        (CLK),
    .rst_ni       (RST),
    .rx_i         (RX_IN),
    .edge_cnt_i   (edge_q),
    .prescale_i   (presc_q),
    .sampled_bit_o(sampled_bit)
  );

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    presc_d  = presc_q;
    bit_d    = bit_q;
    data_d   = data_q;
    perr_d   = perr_q;
    stp_d    = stp_q;
    dv_d     = 1'b0;
    glitch_d = 1'b0;

    if (state_q != IDLE) edge_d = eob ? '0 : edge_q + PRESC_W'(1);

    case (state_q)
      IDLE: begin
        // The detect cycle is edge 0, so the counter resumes at 1
        if (!RX_IN) begin
          state_d = START;
          edge_d  = PRESC_W'(1);
          presc_d = Prescale;
          perr_d  = 1'b0;
          stp_d   = 1'b0;
        end
      end
      START: begin
        if (eob) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (eob) begin
          data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = PAR_EN ? PARITY : STOP;
          else                                 bit_d   = bit_q + BIT_W'(1);
        end
      end
      PARITY: begin
        if (eob) begin
          perr_d  = par_err;
          state_d = STOP;
        end
      end
      STOP: begin
        if (eob) begin
          stp_d   = ~sampled_bit;
          dv_d    = sampled_bit & ~perr_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      presc_q  <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      stp_q    <= 1'b0;
      dv_q     <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      presc_q  <= presc_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      stp_q    <= stp_d;
      dv_q     <= dv_d;
      glitch_q <= glitch_d;
    end
  end

  assign par_chk_en   = (state_q == PARITY) && (edge_q >= vote_edge);
  assign p_data       = data_q;
  assign data_valid   = dv_q;
  assign par_err_flag = perr_q;
  assign stp_err      = stp_q;
  assign strt_glitch  = glitch_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame table plus reset/glitch sequences.
module tb_uart_rx_frame;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          par_err;
  logic [DW-1:0] p_data;
  logic          sampled_bit, par_chk_en, data_valid, par_err_flag, stp_err, strt_glitch;

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .par_err     (par_err),
    .p_data      (p_data),
    .sampled_bit (sampled_bit),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .par_err_flag(par_err_flag),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  // Downstream parity checker: error when the ones count disagrees with the parity type
  assign par_err = (^p_data) ^ sampled_bit ^ PAR_TYP;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [7:0]  data;
    logic        dv;
    logic        perr;
    logic        stp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          presc;
    logic        pe;
    logic        pt;
    logic [7:0]  data;
    logic        pbit;
    logic        stop;
    int          gap;
    logic        dv;
    logic        perr;
    logic        stp;
  } vec_t;

  int   cur_t = -100000;
  int   cur_p = 8;
  logic cur_pe = 1'b0;
  int   exp_glitch = -1;

  always @(negedge CLK) begin : mon
    int   rel;
    logic exp_pce;
    exp_t e;
    if (RST) begin
      rel     = cyc - cur_t;
      exp_pce = cur_pe && (rel >= 9 * cur_p + cur_p / 2 + 2) && (rel <= 10 * cur_p - 1);
      check("par_chk_en", par_chk_en, exp_pce);
      if (strt_glitch || cyc == exp_glitch)
        check("strt_glitch", strt_glitch, cyc == exp_glitch);
      if (sb.size() > 0 && cyc == sb[0].due) begin
        e = sb.pop_front();
        check("data_valid", data_valid, e.dv);
        check("p_data", p_data, e.data);
        check("par_err_flag", par_err_flag, e.perr);
        check("stp_err", stp_err, e.stp);
      end else if (data_valid) begin
        check("data_valid_unexpected", data_valid, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input vec_t v);
    logic [10:0] bv;
    int          nb;
    Prescale = PW'(v.presc);
    PAR_EN   = v.pe;
    PAR_TYP  = v.pt;
    nb       = v.pe ? 11 : 10;
    bv       = '1;
    bv[0]    = 1'b0;
    for (int i = 0; i < 8; i++) bv[1 + i] = v.data[i];
    if (v.pe) begin
      bv[9]  = v.pbit;
      bv[10] = v.stop;
    end else begin
      bv[9]  = v.stop;
    end
    cur_t  = cyc;
    cur_p  = v.presc;
    cur_pe = v.pe;
    sb.push_back('{due: cyc + nb * v.presc, data: v.data, dv: v.dv, perr: v.perr, stp: v.stp});
    for (int b = 0; b < nb; b++) begin
      RX_IN = bv[b];
      for (int k = 0; k < v.presc; k++) begin
        tick();
        if (b == 0 && k == 0) begin
          check("stp_err_cleared_at_start", stp_err, 1'b0);
          check("par_err_flag_cleared_at_start", par_err_flag, 1'b0);
        end
      end
    end
    RX_IN = 1'b1;
    repeat (v.gap) tick();
  endtask

  vec_t       vt[8];
  vec_t       hv;
  logic [7:0] saved;
  int         t0;

  initial begin
    vt[0] = '{presc: 8,  pe: 1'b1, pt: 1'b0, data: 8'hA5, pbit: 1'b0, stop: 1'b1, gap: 4, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    vt[1] = '{presc: 8,  pe: 1'b1, pt: 1'b0, data: 8'hA5, pbit: 1'b1, stop: 1'b1, gap: 4, dv: 1'b0, perr: 1'b1, stp: 1'b0};
    vt[2] = '{presc: 16, pe: 1'b0, pt: 1'b0, data: 8'h3C, pbit: 1'b0, stop: 1'b0, gap: 5, dv: 1'b0, perr: 1'b0, stp: 1'b1};
    vt[3] = '{presc: 16, pe: 1'b0, pt: 1'b0, data: 8'h3C, pbit: 1'b0, stop: 1'b1, gap: 3, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    vt[4] = '{presc: 32, pe: 1'b0, pt: 1'b0, data: 8'h00, pbit: 1'b0, stop: 1'b1, gap: 0, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    vt[5] = '{presc: 32, pe: 1'b0, pt: 1'b0, data: 8'hFF, pbit: 1'b0, stop: 1'b1, gap: 2, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    vt[6] = '{presc: 8,  pe: 1'b1, pt: 1'b1, data: 8'h81, pbit: 1'b1, stop: 1'b1, gap: 0, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    vt[7] = '{presc: 16, pe: 1'b1, pt: 1'b1, data: 8'h01, pbit: 1'b1, stop: 1'b1, gap: 6, dv: 1'b0, perr: 1'b1, stp: 1'b0};

    repeat (3) tick();
    check("reset_p_data", p_data, 8'h00);
    check("reset_sampled_bit", sampled_bit, 1'b1);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_par_chk_en", par_chk_en, 1'b0);
    check("reset_par_err_flag", par_err_flag, 1'b0);
    check("reset_stp_err", stp_err, 1'b0);
    check("reset_strt_glitch", strt_glitch, 1'b0);
    RST = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) send(vt[i]);

    // False start: line low for 3 cycles at Prescale 16
    saved      = p_data;
    Prescale   = 6'd16;
    PAR_EN     = 1'b0;
    cur_pe     = 1'b0;
    cur_t      = -100000;
    RX_IN      = 1'b0;
    t0         = cyc;
    exp_glitch = t0 + 16;
    repeat (3) tick();
    RX_IN = 1'b1;
    repeat (20) tick();
    check("p_data_after_glitch", p_data, saved);

    hv = '{presc: 16, pe: 1'b0, pt: 1'b0, data: 8'hF0, pbit: 1'b0, stop: 1'b1, gap: 3, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    send(hv);

    // Reset in the middle of data bit 4 of a frame of zeros
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    cur_pe   = 1'b0;
    cur_t    = -100000;
    RX_IN    = 1'b0;
    repeat (5 * 8) tick();
    RX_IN = 1'b1;
    repeat (3) tick();
    check("pre_reset_p_data", p_data, 8'h0F);
    check("pre_reset_sampled_bit", sampled_bit, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("async_reset_p_data", p_data, 8'h00);
    check("async_reset_sampled_bit", sampled_bit, 1'b1);
    check("async_reset_data_valid", data_valid, 1'b0);
    check("async_reset_par_chk_en", par_chk_en, 1'b0);
    check("async_reset_par_err_flag", par_err_flag, 1'b0);
    check("async_reset_stp_err", stp_err, 1'b0);
    check("async_reset_strt_glitch", strt_glitch, 1'b0);
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();

    hv = '{presc: 8, pe: 1'b1, pt: 1'b1, data: 8'h5A, pbit: 1'b1, stop: 1'b1, gap: 4, dv: 1'b1, perr: 1'b0, stp: 1'b0};
    send(hv);

    for (int w = 0; w < 2000 && sb.size() > 0; w++) tick();
    if (sb.size() > 0) check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
